// File: rtl/weight_bias_loader_if.sv
// Coefficient stream handshake between the upstream source and weight_bias_loader.
// A transfer happens on any clock where in_valid && in_ready.
interface weight_bias_loader_if #(
  parameter int SIZE_bias = 16
);
  logic [SIZE_bias-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/weight_bias_loader.sv
// Packs a serial coefficient stream into 3x3 kernel words for weight memory, then writes biases.
// Optional LOADER_CHECKSUM_EN adds a 32-bit sign-extended running sum of accepted samples.
module weight_bias_loader #(
  parameter int SIZE_weights     = 8,
  parameter int SIZE_bias        = 16,
  parameter int SIZE_address_wei = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [SIZE_address_wei-1:0]   num_w,
  input  logic [10:0]                   num_b,
  input  logic [SIZE_address_wei-1:0]   base_w,
  weight_bias_loader_if.slave           stream,
  output logic                          we_w,
  output logic [SIZE_address_wei-1:0]   write_addressw,
  output logic [9*SIZE_weights-1:0]     dw,
  output logic                          we_bias,
  output logic [10:0]                   write_address_bias,
  output logic [SIZE_bias-1:0]          d_bias,
  output logic                          busy,
  output logic                          done
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]                   checksum
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD_W = 2'd1;
  localparam logic [1:0] LOAD_B = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [SIZE_address_wei-1:0] W_ONE = SIZE_address_wei'(1);

  logic [1:0]                  state_reg;
  logic [SIZE_address_wei-1:0] num_w_reg;
  logic [10:0]                 num_b_reg;
  logic [SIZE_address_wei-1:0] base_w_reg;
  logic [SIZE_address_wei-1:0] word_reg;
  logic [10:0]                 bias_idx_reg;
  logic [3:0]                  lane_reg;
  logic [8*SIZE_weights-1:0]   pack_reg;

  logic                        we_w_reg;
  logic [SIZE_address_wei-1:0] write_addressw_reg;
  logic [9*SIZE_weights-1:0]   dw_reg;
  logic                        we_bias_reg;
  logic [10:0]                 write_address_bias_reg;
  logic [SIZE_bias-1:0]        d_bias_reg;

  logic in_ready_int;
  logic accept;
  logic last_lane;
  logic last_word;
  logic last_bias;

  assign in_ready_int = (state_reg == LOAD_W) || (state_reg == LOAD_B);
  assign accept       = stream.in_valid && in_ready_int;
  assign last_lane    = (lane_reg == 4'd8);
  assign last_word    = (word_reg == num_w_reg - W_ONE);
  assign last_bias    = (bias_idx_reg == num_b_reg - 11'd1);

  assign stream.in_ready    = in_ready_int;
  assign busy               = (state_reg != IDLE);
  assign done               = (state_reg == DONE);
  assign we_w               = we_w_reg;
  assign write_addressw     = write_addressw_reg;
  assign dw                 = dw_reg;
  assign we_bias            = we_bias_reg;
  assign write_address_bias = write_address_bias_reg;
  assign d_bias             = d_bias_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg              <= IDLE;
      num_w_reg              <= '0;
      num_b_reg              <= '0;
      base_w_reg             <= '0;
      word_reg               <= '0;
      bias_idx_reg           <= '0;
      lane_reg               <= '0;
      we_w_reg               <= 1'b0;
      write_addressw_reg     <= '0;
      dw_reg                 <= '0;
      we_bias_reg            <= 1'b0;
      write_address_bias_reg <= '0;
      d_bias_reg             <= '0;
    end else begin
      we_w_reg    <= 1'b0;
      we_bias_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            num_w_reg    <= num_w;
            num_b_reg    <= num_b;
            base_w_reg   <= base_w;
            word_reg     <= '0;
            bias_idx_reg <= '0;
            lane_reg     <= '0;
            if (num_w != '0)      state_reg <= LOAD_W;
            else if (num_b != '0) state_reg <= LOAD_B;
            else                  state_reg <= DONE;
          end
        end
        LOAD_W: begin
          if (accept) begin
            if (last_lane) begin
              // Ninth sample goes straight into the MSB lane of the written word.
              lane_reg           <= '0;
              we_w_reg           <= 1'b1;
              dw_reg             <= {stream.in_data[SIZE_weights-1:0], pack_reg};
              write_addressw_reg <= base_w_reg + word_reg;
              word_reg           <= word_reg + W_ONE;
              if (last_word) state_reg <= (num_b_reg != '0) ? LOAD_B : DONE;
            end else begin
              lane_reg <= lane_reg + 4'd1;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            we_bias_reg            <= 1'b1;
            d_bias_reg             <= stream.in_data;
            write_address_bias_reg <= bias_idx_reg;
            bias_idx_reg           <= bias_idx_reg + 11'd1;
            if (last_bias) state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Lanes 0..7 of the current kernel are held until the ninth sample arrives.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (rst) begin
          pack_reg[gi*SIZE_weights +: SIZE_weights] <= '0;
        end else if ((state_reg == LOAD_W) && accept && (lane_reg == 4'(gi))) begin
          pack_reg[gi*SIZE_weights +: SIZE_weights] <= stream.in_data[SIZE_weights-1:0];
        end
      end
    end
  endgenerate

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_reg;
  logic [31:0] sample_ext;

  always_comb begin
    sample_ext = {{(32-SIZE_bias){stream.in_data[SIZE_bias-1]}}, stream.in_data};
    if (state_reg == LOAD_W)
      sample_ext = {{(32-SIZE_weights){stream.in_data[SIZE_weights-1]}},
                    stream.in_data[SIZE_weights-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst)                              checksum_reg <= '0;
    else if ((state_reg == IDLE) && start) checksum_reg <= '0;
    else if (accept)                      checksum_reg <= checksum_reg + sample_ext;
  end

  assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_weight_bias_loader.sv
// Randomized self-checking bench for weight_bias_loader with a queue-based reference model.
// Expected writes are derived from the sample list of each job before it is streamed.
module tb_weight_bias_loader;
  localparam int SW = 8;
  localparam int SB = 16;
  localparam int SA = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [SA-1:0]   num_w = '0;
  logic [10:0]     num_b = '0;
  logic [SA-1:0]   base_w = '0;
  logic            we_w, we_bias, busy, done;
  logic [SA-1:0]   write_addressw;
  logic [9*SW-1:0] dw;
  logic [10:0]     write_address_bias;
  logic [SB-1:0]   d_bias;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     checksum;
`endif

  weight_bias_loader_if #(.SIZE_bias(SB)) stream_if ();

  weight_bias_loader #(
    .SIZE_weights(SW), .SIZE_bias(SB), .SIZE_address_wei(SA)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_w(num_w), .num_b(num_b), .base_w(base_w),
    .stream(stream_if),
    .we_w(we_w), .write_addressw(write_addressw), .dw(dw),
    .we_bias(we_bias), .write_address_bias(write_address_bias), .d_bias(d_bias),
    .busy(busy), .done(done)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [SA-1:0]   ew_addr[$];
  logic [9*SW-1:0] ew_data[$];
  logic [10:0]     eb_addr[$];
  logic [SB-1:0]   eb_data[$];
  logic [SB-1:0]   stim_q[$];
  logic [31:0]     exp_sum = '0;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write pulse must match the head of the expected queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (we_w && we_bias) check_eq("we_exclusive", 1, 0);
      if (we_w) begin
        $display("wr_w addr=%0d data=%h", write_addressw, dw);
        if (ew_addr.size() == 0) check_eq("we_w_unexpected", 1, 0);
        else begin
          check_eq("w_addr", write_addressw, ew_addr.pop_front());
          check_eq("w_data", dw, ew_data.pop_front());
        end
      end
      if (we_bias) begin
        $display("wr_b addr=%0d data=%h", write_address_bias, d_bias);
        if (eb_addr.size() == 0) check_eq("we_bias_unexpected", 1, 0);
        else begin
          check_eq("b_addr", write_address_bias, eb_addr.pop_front());
          check_eq("b_data", d_bias, eb_data.pop_front());
        end
      end
      if (!busy) check_eq("ready_idle", stream_if.in_ready, 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        $display("done cyc=%0d", cyc);
        check_eq("pending_at_done", ew_addr.size() + eb_addr.size(), 0);
`ifdef LOADER_CHECKSUM_EN
        check_eq("checksum", checksum, exp_sum);
`endif
      end
    end
  end

  task automatic run_job(input int nw, input int nb, input int base, input int vmode,
                         input bit poke_start);
    int total;
    int idx;
    int cycles;
    int acc_cyc;
    int d0;
    logic [SB-1:0]   samples[$];
    logic [SB-1:0]   s;
    logic [9*SW-1:0] word;
    logic signed [SW-1:0] ws;
    logic signed [SB-1:0] bs;
    total = nw * 9 + nb;
    d0 = done_cnt;
    exp_sum = '0;
    for (int i = 0; i < total; i++) begin
      if (stim_q.size() > 0) s = stim_q.pop_front();
      else s = SB'($urandom);
      samples.push_back(s);
      if (i < nw * 9) begin
        ws = s[SW-1:0];
        exp_sum = exp_sum + int'(ws);
      end else begin
        bs = s;
        exp_sum = exp_sum + int'(bs);
      end
    end
    for (int j = 0; j < nw; j++) begin
      word = '0;
      for (int k = 0; k < 9; k++) begin
        s = samples[j*9 + k];
        word[k*SW +: SW] = s[SW-1:0];
      end
      ew_addr.push_back(SA'((base + j) % (1 << SA)));
      ew_data.push_back(word);
    end
    for (int i = 0; i < nb; i++) begin
      eb_addr.push_back(11'(i));
      eb_data.push_back(samples[nw*9 + i]);
    end
    $display("job nw=%0d nb=%0d base=%0d vmode=%0d poke=%0d", nw, nb, base, vmode, poke_start);

    @(posedge clk); #1;
    num_w = SA'(nw); num_b = 11'(nb); base_w = SA'(base); start = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cycles = 0;
    while (idx < total && cycles < 2000) begin
      case (vmode)
        0:       stream_if.in_valid = 1'b1;
        1:       stream_if.in_valid = (cycles % 2 == 0);
        default: stream_if.in_valid = 1'($urandom_range(0, 1));
      endcase
      stream_if.in_data = samples[idx];
      if (poke_start && cycles == 6) begin
        start = 1'b1; num_w = 13'd5; num_b = 11'd7; base_w = 13'd1234;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (stream_if.in_valid && stream_if.in_ready) begin
        idx++;
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
      cycles++;
    end
    stream_if.in_valid = 1'b0;
    start = 1'b0;
    check_eq("stream_budget", idx, total);
    for (int w = 0; w < 20 && done_cnt == d0; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("done_timing", done_cyc, acc_cyc + 1);
    check_eq("busy_after", busy, 0);
    check_eq("w_left", ew_addr.size(), 0);
    check_eq("b_left", eb_addr.size(), 0);
    ew_addr.delete(); ew_data.delete(); eb_addr.delete(); eb_data.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_we_w"}, we_w, 0);
    check_eq({tag, "_we_bias"}, we_bias, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_ready"}, stream_if.in_ready, 0);
    check_eq({tag, "_waddr"}, write_addressw, 0);
    check_eq({tag, "_dw"}, dw, 0);
    check_eq({tag, "_baddr"}, write_address_bias, 0);
    check_eq({tag, "_dbias"}, d_bias, 0);
`ifdef LOADER_CHECKSUM_EN
    check_eq({tag, "_checksum"}, checksum, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    stream_if.in_valid = 1'b0;
    stream_if.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 1; i <= 9; i++) stim_q.push_back(SB'(i));
    run_job(1, 0, 100, 0, 1'b0);

    stim_q.push_back(16'hFFFB);
    stim_q.push_back(16'h0000);
    stim_q.push_back(16'h7FFF);
    run_job(0, 3, 0, 0, 1'b0);

    run_job(2, 0, 8190, 1, 1'b0);
    run_job(2, 0, 8191, 1, 1'b0);
    run_job(2, 2, 300, 0, 1'b1);
    run_job(0, 0, 0, 0, 1'b0);

    // Abort after five weights of word 0; nothing may be written.
    @(posedge clk); #1;
    num_w = 13'd1; num_b = 11'd0; base_w = 13'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stream_if.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stream_if.in_data = SB'($urandom);
      @(posedge clk); #1;
    end
    stream_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("abort");
    rst = 1'b0;
    for (int i = 0; i < 9; i++) stim_q.push_back(SB'(16'h0A0 + i));
    run_job(1, 0, 77, 0, 1'b0);

    for (int i = 0; i < 9; i++) stim_q.push_back(16'hFFFF);
    stim_q.push_back(16'd10);
    run_job(1, 1, 5, 0, 1'b0);
    check_eq("sum_model_ref", exp_sum, 32'd1);

    for (int r = 0; r < 6; r++)
      run_job($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 8191), 2, 1'(r % 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/weight_bias_loader.md
Name: weight_bias_loader

Overview:
- Write-side feeder for the conv layer's weight and bias memories.
- Accepts a serial stream of signed coefficients over a valid/ready handshake.
- Packs each group of 9 consecutive weights (one 3x3 kernel) into one weight-memory word and drives the we_w/write_addressw/dw write port.
- Then writes bias values one per word on the we_bias/write_address_bias/d_bias port.
- One load job is started by a start pulse from the layer controller.

Parameters:
- SIZE_weights, 8, bit width of one weight; dw is 9*SIZE_weights wide.
- SIZE_bias, 16, bit width of one bias; must be >= SIZE_weights.
- SIZE_address_wei, 13, weight word address width.

Ports:
- clk  in  1  single clock, also used as clk_RAM_w by the memory.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- num_w  in  SIZE_address_wei  number of packed 9-weight words to load; latched on start.
- num_b  in  11  number of biases to load; latched on start.
- base_w  in  SIZE_address_wei  first weight word address; latched on start.
- in_data  in  SIZE_bias  stream data; a weight uses in_data[SIZE_weights-1:0], a bias uses all bits.
- in_valid  in  1  stream data valid.
- in_ready  out  1  stream ready; a transfer occurs when in_valid && in_ready.
- we_w  out  1  weight write enable.
- write_addressw  out  SIZE_address_wei  weight write address.
- dw  out  9*SIZE_weights  packed weight word.
- we_bias  out  1  bias write enable.
- write_address_bias  out  11  bias write address.
- d_bias  out  SIZE_bias  bias data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state=IDLE. All outputs are 0: in_ready, we_w, we_bias, busy, done, write_addressw, dw, write_address_bias, d_bias. Internal counters, lane index and pack register are cleared.
- FSM states: IDLE, LOAD_W, LOAD_B, DONE.
- IDLE:
  - On start, latch num_w, num_b and base_w.
  - Next state: LOAD_W if num_w != 0; else LOAD_B if num_b != 0; else DONE.
- LOAD_W:
  - in_ready=1.
  - The k-th accepted sample of a group (k=0..8) is stored in the pack register at bits [k*SIZE_weights +: SIZE_weights]. Sample 0 occupies the LSBs.
  - On the 9th accept, the cycle after it: we_w=1, dw=packed word, write_addressw = base_w + word_index, with wrap modulo 2^SIZE_address_wei. we_w is a single-cycle pulse.
  - The lane index resets to 0 on the 9th accept. Back-to-back accepts are allowed with no bubble.
  - After accepting the last sample of word num_w-1: in_ready drops the same cycle (registered low next cycle). Next state is LOAD_B if num_b != 0, else DONE.
- LOAD_B:
  - in_ready=1.
  - Each accept produces, the next cycle: we_bias=1, d_bias=in_data, write_address_bias = bias index starting at 0.
  - After num_b accepts, go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - The final we_w or we_bias pulse occurs no later than the done cycle.
- in_valid low stalls without losing pack state. Data presented while in IDLE or DONE is not accepted (in_ready=0).
- start while busy is ignored.
- rst asserted mid-job aborts immediately: the partial pack is discarded and no further write pulses are issued.
- we_w and we_bias are never high in the same cycle.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [31:0].
  - checksum is cleared on accepted start.
  - Every accepted sample is added, as a sign-extended in_data value (weights sign-extended from SIZE_weights, biases from SIZE_bias), modulo 2^32.
  - The value is stable from the done cycle until the next start. Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic weight word: num_w=1, num_b=0, base_w=100, stream 1..9 continuous -> one we_w pulse with write_addressw=100 and dw lanes 0..8 = 1..9; then done one cycle later; busy low after.
- Bias only: num_w=0, num_b=3, stream -5, 0, 32767 -> three we_bias pulses at addresses 0, 1, 2 with d_bias = -5, 0, 32767; no we_w; single done.
- Backpressure: num_w=2, base_w=8190, in_valid toggling 1010... -> two we_w pulses at addresses 8190 and 8191, packed data correct; followed by wrap test with base_w=8191 giving addresses 8191 then 0.
- Protocol guards: start pulse during LOAD_W is ignored, counts unchanged; num_w=0 and num_b=0 -> done in 2 cycles with no writes; in_ready=0 in IDLE.
- Reset mid-job: rst after 5 weights of word 0 -> all outputs 0 next cycle, no we_w; a fresh job then packs from lane 0.
- Checksum (LOADER_CHECKSUM_EN): 9 weights of -1 (8-bit) plus bias 10 -> checksum = 1 at done.
